// File: rtl/cpmath_pkg.sv
// Shared encodings for the CPMath multicycle controller: opcodes, FSM states,
// ALU operation and ALU B-operand select codes, and the registered control word.
package cpmath_pkg;

  localparam int CP_OPW    = 6;
  localparam int CP_ALUOPW = 3;

  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_IRLD      = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_ALU  = 4'd3,
    S_EXEC_ADDR = 4'd4,
    S_MEM_RD    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_WB_ALU    = 4'd7,
    S_WB_MEM    = 4'd8,
    S_BRANCH    = 4'd9,
    S_HALT      = 4'd10
  } state_e;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_c;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       halted;
    logic       illegal_op;
  } ctrl_out_t;

endpackage

// File: rtl/multicycle_ctrl_opdecode.sv
// Combinational opcode classifier: instruction class flags plus the ALU
// operation used in the execute step of register-immediate instructions.
module ctrl_opdecode
  import cpmath_pkg::*;
#(
  parameter int OPW    = CP_OPW,
  parameter int ALUOPW = CP_ALUOPW
) (
  input  logic [OPW-1:0]    opcode_i,
  output logic              is_alu_o,
  output logic              is_mem_o,
  output logic              is_ld_o,
  output logic              is_beq_o,
  output logic              is_halt_o,
  output logic              is_bad_o,
  output logic [ALUOPW-1:0] alu_op_o
);

  always_comb begin
    is_alu_o  = 1'b0;
    is_mem_o  = 1'b0;
    is_ld_o   = 1'b0;
    is_beq_o  = 1'b0;
    is_halt_o = 1'b0;
    is_bad_o  = 1'b0;
    alu_op_o  = ALU_ADD;
    case (opcode_i)
      OP_ADDI: is_alu_o = 1'b1;
      OP_ANDI: begin
        is_alu_o = 1'b1;
        alu_op_o = ALU_AND;
      end
      OP_ORI: begin
        is_alu_o = 1'b1;
        alu_op_o = ALU_OR;
      end
      OP_LW: begin
        is_mem_o = 1'b1;
        is_ld_o  = 1'b1;
      end
      OP_SW:   is_mem_o = 1'b1;
      OP_BEQ: begin
        is_beq_o = 1'b1;
        alu_op_o = ALU_SUB;
      end
      OP_HALT: is_halt_o = 1'b1;
      default: is_bad_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the CPMath core. Every control output is a flop
// loaded from the decode of the next state, so nothing downstream sees a glitch.
module multicycle_ctrl
  import cpmath_pkg::*;
#(
  parameter int OPW    = CP_OPW,
  parameter int ALUOPW = CP_ALUOPW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [OPW-1:0]    opcode,
  input  logic              mem_ready,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              iord,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_write_c,
  output logic              pc_src,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic              halted,
  output logic              illegal_op
);

  state_e    state_q, state_d;
  ctrl_out_t out_q, out_d;

  logic              is_alu, is_mem, is_ld, is_beq, is_halt, is_bad;
  logic [ALUOPW-1:0] dec_alu_op;

  ctrl_opdecode #(.OPW(OPW), .ALUOPW(ALUOPW)) u_opdecode (
    .opcode_i (opcode),
    .is_alu_o (is_alu),
    .is_mem_o (is_mem),
    .is_ld_o  (is_ld),
    .is_beq_o (is_beq),
    .is_halt_o(is_halt),
    .is_bad_o (is_bad),
    .alu_op_o (dec_alu_op)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      // The fetch completes only against a request that is actually on the bus.
      S_FETCH:     if (out_q.mem_rd && mem_ready) state_d = S_IRLD;
      S_IRLD:      state_d = S_DECODE;
      S_DECODE: begin
        if (is_alu)       state_d = S_EXEC_ALU;
        else if (is_mem)  state_d = S_EXEC_ADDR;
        else if (is_beq)  state_d = S_BRANCH;
        else if (is_halt) state_d = S_HALT;
        else              state_d = S_FETCH;
      end
      S_EXEC_ALU:  state_d = S_WB_ALU;
      S_EXEC_ADDR: state_d = is_ld ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
      S_WB_ALU:    state_d = S_FETCH;
      S_WB_MEM:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    out_d = '0;
    case (state_d)
      S_FETCH: begin
        // Once issued, a fetch request stays up until memory answers it.
        out_d.mem_rd     = run | ((state_q == S_FETCH) & out_q.mem_rd);
        out_d.illegal_op = (state_q == S_DECODE);
      end
      S_IRLD: begin
        out_d.ir_write  = 1'b1;
        out_d.pc_write  = 1'b1;
        out_d.alu_src_b = SRCB_FOUR;
        out_d.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        out_d.alu_src_b = SRCB_IMM_SH2;
        out_d.alu_op    = ALU_ADD;
      end
      S_EXEC_ALU: begin
        out_d.alu_src_a = 1'b1;
        out_d.alu_src_b = SRCB_IMM;
        out_d.alu_op    = 3'(dec_alu_op);
      end
      S_EXEC_ADDR: begin
        out_d.alu_src_a = 1'b1;
        out_d.alu_src_b = SRCB_IMM;
        out_d.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        out_d.mem_rd = 1'b1;
        out_d.iord   = 1'b1;
      end
      S_MEM_WR: begin
        out_d.mem_wr = 1'b1;
        out_d.iord   = 1'b1;
      end
      S_WB_ALU:  out_d.reg_write = 1'b1;
      S_WB_MEM: begin
        out_d.reg_write  = 1'b1;
        out_d.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        out_d.alu_src_a  = 1'b1;
        out_d.alu_src_b  = SRCB_RT;
        out_d.alu_op     = ALU_SUB;
        out_d.pc_write_c = 1'b1;
        out_d.pc_src     = 1'b1;
      end
      S_HALT:    out_d.halted = 1'b1;
      default:   out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign mem_rd     = out_q.mem_rd;
  assign mem_wr     = out_q.mem_wr;
  assign iord       = out_q.iord;
  assign ir_write   = out_q.ir_write;
  assign pc_write   = out_q.pc_write;
  assign pc_write_c = out_q.pc_write_c;
  assign pc_src     = out_q.pc_src;
  assign alu_src_a  = out_q.alu_src_a;
  assign alu_src_b  = out_q.alu_src_b;
  assign alu_op     = ALUOPW'(out_q.alu_op);
  assign reg_write  = out_q.reg_write;
  assign mem_to_reg = out_q.mem_to_reg;
  assign halted     = out_q.halted;
  assign illegal_op = out_q.illegal_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues the expected control
// word and spacing of each notable cycle; a monitor pops and compares them.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, run, mem_ready;
  logic [5:0] opcode;
  logic       mem_rd, mem_wr, iord, ir_write, pc_write, pc_write_c, pc_src, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       reg_write, mem_to_reg, halted, illegal_op;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OPW(6), .ALUOPW(3)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_c(pc_write_c), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted),
    .illegal_op(illegal_op)
  );

  // {mem_rd,mem_wr,iord,ir_write,pc_write,pc_write_c,pc_src,alu_src_a,alu_src_b,alu_op,reg_write,mem_to_reg,halted,illegal_op}
  logic [16:0] obs;
  assign obs = {mem_rd, mem_wr, iord, ir_write, pc_write, pc_write_c, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_write, mem_to_reg, halted, illegal_op};

  localparam logic [16:0] E_IRLD   = 17'b0_0_0_1_1_0_0_0_01_000_0_0_0_0;
  localparam logic [16:0] E_EXADDR = 17'b0_0_0_0_0_0_0_1_10_000_0_0_0_0;
  localparam logic [16:0] E_MEMRD  = 17'b1_0_1_0_0_0_0_0_00_000_0_0_0_0;
  localparam logic [16:0] E_MEMWR  = 17'b0_1_1_0_0_0_0_0_00_000_0_0_0_0;
  localparam logic [16:0] E_WBALU  = 17'b0_0_0_0_0_0_0_0_00_000_1_0_0_0;
  localparam logic [16:0] E_WBMEM  = 17'b0_0_0_0_0_0_0_0_00_000_1_1_0_0;
  localparam logic [16:0] E_BR     = 17'b0_0_0_0_0_1_1_1_00_001_0_0_0_0;
  localparam logic [16:0] E_ILL    = 17'b1_0_0_0_0_0_0_0_00_000_0_0_0_1;
  localparam logic [16:0] E_HALT   = 17'b0_0_0_0_0_0_0_0_00_000_0_0_1_0;

  typedef struct {
    logic [16:0] v;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   gap_cnt = 0;
  int   next_gap = -1;
  bit   mon_en = 1'b0;
  bit   prev_ir = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] e_exalu(input logic [2:0] op);
    return {8'b0000_0001, 2'b10, op, 4'b0000};
  endfunction

  function automatic void push(input logic [16:0] v, input int gap);
    exp_t e;
    e.v   = v;
    e.gap = gap;
    q.push_back(e);
  endfunction

  // Monitor: invariants every cycle, scoreboard pop on every notable cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      gap_cnt = 0;
      prev_ir = 1'b0;
    end else begin
      gap_cnt++;
      check("invariants", {29'b0, ir_write & prev_ir,
                           (ir_write & reg_write) | (ir_write & mem_wr) | (reg_write & mem_wr),
                           mem_rd & mem_wr}, 32'd0);
      prev_ir = ir_write;
      if (mon_en && (ir_write | reg_write | mem_wr | pc_write_c | illegal_op | alu_src_a |
                     (mem_rd & iord) | halted)) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_event: got %h expected no event", obs);
        end else begin
          e = q.pop_front();
          check("event_word", {15'b0, obs}, {15'b0, e.v});
          if (e.gap >= 0) check("event_gap", gap_cnt, e.gap);
        end
        gap_cnt = 0;
      end
    end
  end

  task automatic wait_cond(input int sel, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      case (sel)
        0:       ok = ir_write;
        1:       ok = mem_rd & iord;
        2:       ok = halted;
        default: ok = (mem_rd | mem_wr) & iord;
      endcase
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL wait_%s: got no event in 200 cycles expected one", name);
    end
  endtask

  // Queue the expected cycle sequence of one instruction, then drive it.
  task automatic run_instr(input logic [5:0] op, input int d);
    push(E_IRLD, next_gap);
    case (op)
      6'h08: begin push(e_exalu(3'b000), 2); push(E_WBALU, 1); next_gap = 2; end
      6'h0C: begin push(e_exalu(3'b010), 2); push(E_WBALU, 1); next_gap = 2; end
      6'h0D: begin push(e_exalu(3'b011), 2); push(E_WBALU, 1); next_gap = 2; end
      6'h23: begin
        push(E_EXADDR, 2);
        for (int i = 0; i <= d; i++) push(E_MEMRD, 1);
        push(E_WBMEM, 1);
        next_gap = 2;
      end
      6'h2B: begin
        push(E_EXADDR, 2);
        for (int i = 0; i <= d; i++) push(E_MEMWR, 1);
        next_gap = 2;
      end
      6'h04: begin push(E_BR, 2); next_gap = 2; end
      6'h3F: begin
        push(E_HALT, 2);
        for (int i = 0; i < 99; i++) push(E_HALT, 1);
        next_gap = -1;
      end
      default: begin push(E_ILL, 2); next_gap = 1; end
    endcase
    wait_cond(0, "irld");
    opcode = op;
    if ((op == 6'h23 || op == 6'h2B) && d > 0) begin
      mem_ready = 1'b0;
      wait_cond(3, "data_access");
      repeat (d) @(negedge clk);
      mem_ready = 1'b1;
    end
  endtask

  logic [5:0] soak_ops [8];

  initial begin
    soak_ops = '{6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h3E, 6'h00};
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 6'h23;

    // Reset and idle behaviour, including a reset landing mid data read.
    repeat (2) @(negedge clk);
    check("reset_outputs", {15'b0, obs}, 32'd0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_no_fetch", {31'b0, mem_rd}, 32'd0);
    end
    run = 1'b1; mem_ready = 1'b1;
    wait_cond(0, "first_irld");
    mem_ready = 1'b0;
    wait_cond(1, "lw_access");
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_access", {15'b0, obs}, 32'd0);
    run = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_no_fetch", {31'b0, mem_rd}, 32'd0);
    end
    run = 1'b1;
    @(negedge clk);
    check("fetch_issued", {30'b0, mem_rd, iord}, 32'd2);
    @(negedge clk);
    check("fetch_held", {30'b0, mem_rd, ir_write}, 32'd2);

    // Scoreboarded instruction stream.
    #1 rst_n = 1'b0;
    mon_en = 1'b1; next_gap = -1; mem_ready = 1'b1; run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(6'h08, 0);
    run_instr(6'h0C, 0);
    run_instr(6'h0D, 0);
    run_instr(6'h23, 3);
    run_instr(6'h2B, 2);
    run_instr(6'h04, 0);
    run_instr(6'h3E, 0);
    run_instr(6'h23, 0);
    run_instr(6'h08, 0);
    run_instr(6'h3F, 0);
    wait_cond(2, "halt");
    repeat (99) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("queue_drained", q.size(), 32'd0);

    // Random soak for the protocol invariants.
    mon_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      if (ir_write) opcode = soak_ops[$urandom_range(0, 7)];
    end
    #1 rst_n = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
